// File: rtl/uart_tx_ctrl_pkg.sv
// Shared constants for the UART transmit path: FSM state encoding and the
// TX output mux select codes (the downstream mux decodes the same values).
package uart_tx_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_STOP  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

  // Bit counter width; a 1-bit frame still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Parallel-to-serial shifter for the UART transmitter. Loads the data word on
// accept, presents the LSB as the current bit and shifts right once per DATA
// cycle. ser_done flags the cycle in which the final bit is on the line.
module uart_tx_serializer
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int unsigned CntW = cnt_width(DATA_WIDTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  last_bit;

  assign last_bit = (cnt_q == LastIdx);

  // Next-state for shift register and bit counter; load has priority.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = din;
      cnt_d   = '0;
    end else if (shift) begin
      shreg_d = shreg_q >> 1;
      // Return to zero after the last bit rather than running past it.
      cnt_d   = last_bit ? '0 : cnt_q + CntW'(1);
    end
  end

  // Shift register and bit counter state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ser_data = shreg_q[0];
  assign ser_done = shift && last_bit;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller. Accepts a byte on a one-cycle strobe, sequences
// start / data / parity / stop by driving the TX mux select, and supplies the
// serial data bit and the frame parity bit. All outputs come from registers.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  state_t state_q, state_d;
  logic   par_en_q, par_en_d;
  logic   par_bit_q, par_bit_d;
  logic   accept;
  logic   shift;
  logic   ser_done;

  // Strobes outside IDLE are dropped so a frame in flight is never disturbed.
  assign accept = (state_q == IDLE) && Data_Valid;
  assign shift  = (state_q == DATA);

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (accept),
    .shift    (shift),
    .din      (P_DATA),
    .ser_data (ser_data),
    .ser_done (ser_done)
  );

  // Frame sequencing and capture of per-frame options on accept.
  always_comb begin
    state_d   = state_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          state_d   = START;
          par_en_d  = PAR_EN;
          // Even parity is the XOR of the data; odd inverts it.
          par_bit_d = (^P_DATA) ^ PAR_TYP;
        end
      end
      START:   state_d = DATA;
      DATA: begin
        if (ser_done) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and latched frame options.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    mux_sel = SEL_STOP;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        mux_sel = SEL_STOP;
        busy    = 1'b0;
      end
      START: begin
        mux_sel = SEL_START;
        busy    = 1'b1;
      end
      DATA: begin
        mux_sel = SEL_DATA;
        busy    = 1'b1;
      end
      PARITY: begin
        mux_sel = SEL_PAR;
        busy    = 1'b1;
      end
      STOP: begin
        mux_sel = SEL_STOP;
        busy    = 1'b1;
      end
      default: begin
        mux_sel = SEL_STOP;
        busy    = 1'b0;
      end
    endcase
  end

  assign par_bit = par_bit_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: a table of frames checked bit by bit, plus
// hand-written sequences for mid-frame reset and ignored strobes.
module tb_uart_tx_ctrl;
  import uart_tx_ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [1:0] mux_sel;
  logic       ser_data;
  logic       par_bit;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       exp_par;
    int         exp_len;
    int         gap;   // idle cycles before this frame
    bit         intr;  // pulse Data_Valid with 8'hFF during data bit 3
  } vec_t;

  vec_t vecs[7];

  uart_tx_ctrl #(
    .DATA_WIDTH (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Entered 1 time unit after an edge with the DUT in IDLE; leaves it in the
  // first IDLE cycle after the frame, so a following call is back-to-back.
  task automatic run_frame(input vec_t v);
    int blen;
    blen       = 0;
    P_DATA     = v.data;
    PAR_EN     = v.pe;
    PAR_TYP    = v.pt;
    Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    // Scramble inputs after acceptance; the frame must not notice.
    P_DATA     = ~v.data;
    PAR_EN     = ~v.pe;
    PAR_TYP    = ~v.pt;
    chk("start_sel", 32'(mux_sel), 32'(SEL_START));
    chk("start_busy", 32'(busy), 32'd1);
    blen += int'(busy);
    for (int k = 0; k < 8; k++) begin
      step();
      if (v.intr && k == 3) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'hFF;
      end else begin
        Data_Valid = 1'b0;
      end
      chk("data_sel", 32'(mux_sel), 32'(SEL_DATA));
      chk("data_bit", 32'(ser_data), 32'(v.data[k]));
      chk("par_hold", 32'(par_bit), 32'(v.exp_par));
      blen += int'(busy);
    end
    Data_Valid = 1'b0;
    if (v.pe) begin
      step();
      chk("par_sel", 32'(mux_sel), 32'(SEL_PAR));
      chk("par_bit", 32'(par_bit), 32'(v.exp_par));
      blen += int'(busy);
    end
    step();
    chk("stop_sel", 32'(mux_sel), 32'(SEL_STOP));
    chk("stop_busy", 32'(busy), 32'd1);
    blen += int'(busy);
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_sel", 32'(mux_sel), 32'(SEL_STOP));
    chk("busy_len", 32'(blen), 32'(v.exp_len));
  endtask

  initial begin
    //          data   pe    pt    par   len gap intr
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11, 1, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 11, 2, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b0, 1'b0, 11, 1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 11, 0, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 10, 1, 1'b0};
    vecs[5] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11, 1, 1'b1};
    vecs[6] = '{8'h5A, 1'b1, 1'b1, 1'b1, 11, 0, 1'b0};

    RST        = 1'b0;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    #12;
    chk("rst_sel", 32'(mux_sel), 32'(SEL_STOP));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ser", 32'(ser_data), 32'd0);
    chk("rst_par", 32'(par_bit), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    step();

    foreach (vecs[i]) begin
      for (int g = 0; g < vecs[i].gap; g++) begin
        step();
        chk("gap_busy", 32'(busy), 32'd0);
      end
      run_frame(vecs[i]);
    end

    // The strobe during the 8'hA5 frame (vecs[5]) must not start a frame.
    step();
    chk("no_second_busy", 32'(busy), 32'd0);
    chk("no_second_sel", 32'(mux_sel), 32'(SEL_STOP));

    // Reset mid-frame during data bit 3 of an 8'hFF odd-parity frame.
    P_DATA     = 8'hFF;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b1;
    Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("pre_rst_sel", 32'(mux_sel), 32'(SEL_DATA));
    chk("pre_rst_ser", 32'(ser_data), 32'd1);
    chk("pre_rst_par", 32'(par_bit), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    chk("midrst_sel", 32'(mux_sel), 32'(SEL_STOP));
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ser", 32'(ser_data), 32'd0);
    chk("midrst_par", 32'(par_bit), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    run_frame('{8'h81, 1'b1, 1'b0, 1'b0, 11, 0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller. It accepts a parallel byte with a one-cycle valid strobe, serializes it LSB-first and computes optional even or odd parity. It also sequences the frame (start, data, parity, stop) by driving the 2-bit select of the TX output mux. It sits directly upstream of the registered TX output mux and supplies that mux's `mux_sel`, `ser_data` and `par_bit` inputs, plus a `busy` flag for the system controller.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame.
- `CLK`  in  1: TX clock; one bit period per cycle.
- `RST`  in  1: asynchronous, active-low reset.
- `P_DATA`  in  DATA_WIDTH: parallel data to transmit.
- `Data_Valid`  in  1: single-cycle strobe; `P_DATA` is valid while high.
- `PAR_EN`  in  1: 1 = insert a parity bit.
- `PAR_TYP`  in  1: 0 = even parity, 1 = odd parity.
- `mux_sel`  out  2: 00 = start, 01 = stop/idle, 10 = data, 11 = parity.
- `ser_data`  out  1: current data bit.
- `par_bit`  out  1: parity of the latched frame.
- `busy`  out  1: high while a frame is in progress.

## Operation
- Moore FSM with states IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `mux_sel`=01, `busy`=0.
  - If `Data_Valid`=1, latch `P_DATA`, `PAR_EN` and `PAR_TYP`, compute `par_bit`, and go to START.
- START: `mux_sel`=00, `busy`=1. Go to DATA next cycle.
- DATA:
  - `mux_sel`=10, `busy`=1.
  - `ser_data` = bit[k] of the latched data, k = 0..DATA_WIDTH-1, one bit per cycle, LSB first.
  - After bit DATA_WIDTH-1, go to PARITY if the latched `PAR_EN`=1, else go to STOP.
- PARITY: `mux_sel`=11, `busy`=1. Go to STOP.
- STOP: `mux_sel`=01, `busy`=1. Go to IDLE.
- Parity rule:
  - even: `par_bit` = XOR of all data bits.
  - odd: `par_bit` = XNOR of all data bits.
  - `par_bit` is computed from the latched data and held stable for the whole frame.
- `Data_Valid` outside IDLE is ignored. No queuing and no corruption of the frame in progress.
- Changes to `P_DATA`, `PAR_EN` or `PAR_TYP` after acceptance have no effect on the current frame.
- Bit counter width is clog2(DATA_WIDTH). It counts 0..DATA_WIDTH-1 and must not wrap into an extra data cycle.
- Reset, asynchronous at any point including mid-frame:
  - state = IDLE, `mux_sel`=01, `busy`=0, `ser_data`=0, `par_bit`=0.
  - Shift register and bit counter are cleared.
  - A partially sent frame is abandoned.

## Timing
- Acceptance: `Data_Valid` sampled high in IDLE at edge N. START is presented from edge N until edge N+1; `busy` rises at edge N.
- Frame length in `busy` cycles: 1 + DATA_WIDTH + PAR_EN + 1. For DATA_WIDTH=8 this is 11 with parity and 10 without.
- `busy` falls at the edge that enters IDLE. `Data_Valid` in that first IDLE cycle is accepted, so back-to-back frames have zero idle cycles between STOP and the next START.
- All outputs are decoded from registered state and shift register only. They change only on `CLK` edges or on reset assertion.
- The downstream mux registers its output, so the line lags `mux_sel` by exactly one cycle. This controller does not compensate for that.

## Structure
- Shared package / include holds:
  - state encoding localparams: IDLE, START, DATA, PARITY, STOP.
  - `mux_sel` constants: SEL_START=00, SEL_STOP=01, SEL_DATA=10, SEL_PAR=11. The output mux uses the same constants.
- One sub-module, `uart_tx_serializer`:
  - loads `P_DATA` on accept and shifts right on each DATA cycle.
  - outputs `ser_data` (LSB of the shift register) and `ser_done` (last bit presented).
  - the FSM uses `ser_done` for the DATA→PARITY/STOP transition.
- Parity computation is inline in the top level.

## Test plan
- `P_DATA`=8'hA5, `PAR_EN`=1, `PAR_TYP`=0 → `mux_sel` sequence 00, then 10×8, then 11, then 01. `ser_data` = 1,0,1,0,0,1,0,1. `par_bit`=0. `busy` high for 11 cycles.
- Same data, `PAR_TYP`=1 → `par_bit`=1. `P_DATA`=8'h00 with even parity → `par_bit`=0; with odd parity → `par_bit`=1.
- `P_DATA`=8'h3C, `PAR_EN`=0 → no 11 select. `busy` high for 10 cycles; STOP follows the 8th data bit.
- `Data_Valid` pulsed with 8'hFF during the DATA state of an 8'hA5 frame → 8'hA5 is sent intact and no second frame starts.
- Second `Data_Valid` (8'h5A) in the first IDLE cycle after STOP → next START follows immediately. The two frames are correct and contiguous.
- `RST` asserted during the 4th data bit → `mux_sel`=01, `busy`=0 and `ser_data`=0 immediately. After release, a new 8'h81 frame is sent correctly.
